timer_ctrl: RTL and testbench

Programmable interval-timer controller that sequences a single instantiated downcounter (LD/EN/D control, zero detect). Adds a prescaler, a one-shot or auto-reload mode, a GO/STOP command interface and a single-cycle interrupt pulse on expiry. Sits between the memory-mapped timer registers of the processor's peripheral bus and the counter datapath, driving the IRQ line into the interrupt logic.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_ctrl_downcnt.sv | 32 +++
 rtl/timer_ctrl.sv | 122 ++++++++++++
 tb/tb_timer_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: controller state encoding and default widths.
package timer_pkg;

   localparam int TIMER_WIDTH  = 32;
   localparam int TIMER_PWIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_EXPIRE = 2'd3
   } state_e;

endpackage

// File: rtl/timer_ctrl_downcnt.sv
// Loadable downcounter with zero detect; no reset, the controller loads it during RST.
module timer_ctrl_downcnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             ld_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld_i) begin
         cnt_d = d_i;
      end else if (en_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign q_o    = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer controller: FSM, tick prescaler and DONE/IRQ flags around one downcounter.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH  = TIMER_WIDTH,
   parameter int PWIDTH = TIMER_PWIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              GO,
   input  logic              STOP,
   input  logic              AUTO,
   input  logic [WIDTH-1:0]  PERIOD,
   input  logic [PWIDTH-1:0] PRESCALE,
   output logic              BUSY,
   output logic              DONE,
   output logic              IRQ,
   output logic [WIDTH-1:0]  COUNT
);

   state_e            state_q, state_d;
   logic [PWIDTH-1:0] psc_q, psc_d;
   logic [PWIDTH-1:0] pcnt_q, pcnt_d;
   logic              done_q, done_d;

   logic              cnt_ld;
   logic              cnt_en;
   logic [WIDTH-1:0]  cnt_d;
   logic              cnt_zero;
   logic              irq_s;

   timer_ctrl_downcnt #(
      .WIDTH(WIDTH)
   ) u_cnt (
      .clk_i (CLK),
      .ld_i  (cnt_ld),
      .en_i  (cnt_en),
      .d_i   (cnt_d),
      .q_o   (COUNT),
      .zero_o(cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      psc_d   = psc_q;
      pcnt_d  = pcnt_q;
      done_d  = done_q;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      cnt_d   = '0;
      irq_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (GO && !STOP) begin
               psc_d   = PRESCALE;
               done_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_ld  = 1'b1;
            cnt_d   = PERIOD;
            pcnt_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Zero check comes first so EN can never drive the counter below zero.
            if (cnt_zero) begin
               state_d = S_EXPIRE;
            end else if (pcnt_q == psc_q) begin
               cnt_en = 1'b1;
               pcnt_d = '0;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         S_EXPIRE: begin
            irq_s   = 1'b1;
            done_d  = 1'b1;
            state_d = AUTO ? S_LOAD : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // STOP freezes the counter but still lets an expiry pulse out this cycle.
      if (STOP) begin
         state_d = S_IDLE;
         cnt_ld  = 1'b0;
         cnt_en  = 1'b0;
      end

      // The counter has no reset, so it is loaded with zero while RST is held.
      if (RST) begin
         cnt_ld = 1'b1;
         cnt_en = 1'b0;
         cnt_d  = '0;
         irq_s  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         psc_q   <= '0;
         pcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         psc_q   <= psc_d;
         pcnt_q  <= pcnt_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = (state_q != S_IDLE);
   assign DONE = done_q;
   assign IRQ  = irq_s;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboarded bench for timer_ctrl: closed-form timing model feeds a queue drained by a monitor.
module tb_timer_ctrl;

   localparam int W  = 32;
   localparam int PW = 8;

   logic          CLK = 1'b0;
   logic          RST, GO, STOP, AUTO;
   logic [W-1:0]  PERIOD;
   logic [PW-1:0] PRESCALE;
   logic          BUSY, DONE, IRQ;
   logic [W-1:0]  COUNT;

   timer_ctrl #(.WIDTH(W), .PWIDTH(PW)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .GO      (GO),
      .STOP    (STOP),
      .AUTO    (AUTO),
      .PERIOD  (PERIOD),
      .PRESCALE(PRESCALE),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .IRQ     (IRQ),
      .COUNT   (COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] count;
      logic         busy;
      logic         done;
      logic         irq;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: an interval is described by the cycle offset from its LOAD cycle;
   // COUNT and the expiry cycle follow directly from N and P by arithmetic.
   bit     m_active = 1'b0;
   bit     m_done   = 1'b0;
   longint m_rel    = 0;
   longint m_n      = 0;
   longint m_p      = 0;
   longint m_count  = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   task automatic step(input bit rst, input bit go, input bit stop, input bit auto_,
                       input longint period, input longint presc);
      exp_t   e;
      longint v, k, e_rel;
      bit     at_exp;
      RST      = rst;
      GO       = go;
      STOP     = stop;
      AUTO     = auto_;
      PERIOD   = period[W-1:0];
      PRESCALE = presc[PW-1:0];

      e_rel  = 2 + m_n * (m_p + 1);
      at_exp = 1'b0;
      v      = m_count;
      if (m_active) begin
         at_exp = (m_rel != 0) && (m_rel == e_rel);
         if (m_rel != 0) begin
            k = m_rel - 1;
            v = m_n - k / (m_p + 1);
            if (v < 0) v = 0;
         end
      end
      e.count = v[W-1:0];
      e.busy  = m_active;
      e.done  = m_done;
      e.irq   = at_exp && !rst;
      q.push_back(e);

      if (rst) begin
         m_active = 1'b0;
         m_count  = 0;
         m_done   = 1'b0;
      end else if (stop) begin
         if (m_active) begin
            m_count = v;
            if (at_exp) m_done = 1'b1;
         end
         m_active = 1'b0;
      end else if (!m_active) begin
         if (go) begin
            m_active = 1'b1;
            m_rel    = 0;
            m_p      = presc;
            m_done   = 1'b0;
         end
      end else if (m_rel == 0) begin
         m_n   = period;
         m_rel = 1;
      end else if (at_exp) begin
         m_done  = 1'b1;
         m_count = 0;
         if (auto_) m_rel = 0;
         else m_active = 1'b0;
      end else begin
         m_rel++;
      end

      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("count", COUNT, e.count);
         chk("busy", {{(W-1){1'b0}}, BUSY}, {{(W-1){1'b0}}, e.busy});
         chk("done", {{(W-1){1'b0}}, DONE}, {{(W-1){1'b0}}, e.done});
         chk("irq", {{(W-1){1'b0}}, IRQ}, {{(W-1){1'b0}}, e.irq});
         chk("ld_and_en", {{(W-1){1'b0}}, dut.cnt_ld & dut.cnt_en}, '0);
         chk("en_at_zero", {{(W-1){1'b0}}, dut.cnt_en & (COUNT == '0)}, '0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; GO = 1'b0; STOP = 1'b0; AUTO = 1'b0;
      PERIOD = '0; PRESCALE = '0;
      @(posedge CLK);
      #1;

      // Second reset cycle, then idle
      step(1, 0, 0, 0, 0, 0);
      repeat (20) step(0, 0, 0, 0, 0, 0);

      // One-shot, PERIOD=3, PRESCALE=0
      step(0, 1, 0, 0, 3, 0);
      repeat (10) step(0, 0, 0, 0, 3, 0);

      // Prescaled one-shot, PERIOD=2, PRESCALE=3
      step(0, 1, 0, 0, 2, 3);
      repeat (15) step(0, 0, 0, 0, 2, 3);

      // Auto-reload PERIOD=4, shortened to 1 after the first IRQ
      step(0, 1, 0, 1, 4, 0);
      repeat (7) step(0, 0, 0, 1, 4, 0);
      repeat (12) step(0, 0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      repeat (3) step(0, 0, 0, 0, 1, 0);

      // STOP in RUN at COUNT=5 of PERIOD=10
      step(0, 1, 0, 0, 10, 0);
      repeat (6) step(0, 0, 0, 0, 10, 0);
      step(0, 0, 1, 0, 10, 0);
      repeat (3) step(0, 0, 0, 0, 10, 0);

      // GO while busy, then GO together with STOP
      step(0, 1, 0, 0, 10, 1);
      repeat (3) step(0, 0, 0, 0, 10, 1);
      step(0, 1, 0, 0, 7, 0);
      repeat (3) step(0, 0, 0, 0, 7, 0);
      step(0, 0, 1, 0, 7, 0);
      step(0, 1, 1, 0, 5, 0);
      repeat (3) step(0, 0, 0, 0, 5, 0);

      // PERIOD=0
      step(0, 1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0);

      // RST during RUN
      step(0, 1, 0, 0, 8, 0);
      repeat (4) step(0, 0, 0, 0, 8, 0);
      step(1, 0, 0, 0, 8, 0);
      repeat (3) step(0, 0, 0, 0, 8, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 1) == 1,
              longint'($urandom_range(0, 12)),
              longint'($urandom_range(0, 3)));
      end
      repeat (5) step(0, 0, 0, 0, 0, 0);

      @(negedge CLK);
      @(negedge CLK);
      chk("queue_drained", q.size(), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
